// File: rtl/sram_bridge_pkg.sv
// Shared types and sizing constants for the picorv32-to-SRAM bridge.
package sram_bridge_pkg;

    localparam int LANES      = 4;
    localparam int BANK_BYTES = 4096;
    localparam int WORD_AW    = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/sram_bridge_if.sv
// picorv32 native memory bus; mem_err exists only with SRAM_BRIDGE_RANGE_CHECK_EN.
interface sram_bridge_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
    logic        mem_err;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready, mem_err
    );
    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready, mem_err
    );
`else
    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );
    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
`endif

endinterface

// File: rtl/sram_8_1024_sky130A.sv
// Behavioural stand-in for the OpenRAM 1024x8 macro: active-low select/write,
// inputs sampled on the clock edge, read data valid one cycle after select.
module sram_8_1024_sky130A (
    input  logic       clk0,
    input  logic       csb0,
    input  logic       web0,
    input  logic [9:0] addr0,
    input  logic [7:0] din0,
    output logic [7:0] dout0
);

    logic [7:0] mem [1024];

    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) mem[addr0] <= din0;
            else       dout0      <= mem[addr0];
        end
    end

endmodule

// File: rtl/sram_bridge_bank.sv
// One 4 KiB bank (module sram_bank): four byte-lane macros sharing select/address.
module sram_bank
    import sram_bridge_pkg::*;
(
    input  logic               clk,
    input  logic               csb,
    input  logic [LANES-1:0]   web,
    input  logic [WORD_AW-1:0] addr,
    input  logic [31:0]        din,
    output logic [31:0]        dout
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sram_8_1024_sky130A u_lane (
            .clk0  (clk),
            .csb0  (csb),
            .web0  (web[l]),
            .addr0 (addr),
            .din0  (din[8*l +: 8]),
            .dout0 (dout[8*l +: 8])
        );
    end

endmodule

// File: rtl/sram_bridge.sv
// picorv32 to banked sky130 SRAM bridge; SRAM_BRIDGE_RANGE_CHECK_EN enables
// out-of-window detection with a sticky mem_err instead of address wrapping.
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int          BANKS     = 2,
    parameter int          LAT       = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    sram_bridge_if.slave bus
);

    localparam int          BW  = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam logic [31:0] CAP = 32'(BANKS * BANK_BYTES);

    state_t             state;
    logic [WORD_AW-1:0] word_q;
    logic [BW-1:0]      bank_q;
    logic [31:0]        wdata_q;
    logic [LANES-1:0]   wstrb_q;
    logic [1:0]         cnt;
    logic [31:0]        rdata_q;

    logic [31:0]        offset;
    logic [BW-1:0]      bank_d;
    logic [BANKS-1:0]   csb;
    logic [LANES-1:0]   web;
    logic [31:0]        dout [BANKS];
    logic               unused_bits;

    assign offset      = bus.mem_addr - BASE_ADDR;
    assign bank_d      = BW'((offset >> 12) & 32'(BANKS - 1));
    assign unused_bits = ^{offset, bus.mem_instr};

    always_comb begin
        csb = '1;
        if (state == ST_ACCESS) csb[bank_q] = 1'b0;
    end

    assign web = (state == ST_ACCESS) ? ~wstrb_q : '1;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        sram_bank u_bank (
            .clk  (clk),
            .csb  (csb[b]),
            .web  (web),
            .addr (word_q),
            .din  (wdata_q),
            .dout (dout[b])
        );
    end

`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
    logic err_q;
    logic oor;
    assign oor         = offset >= CAP;
    assign bus.mem_err = err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            word_q  <= '0;
            bank_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt     <= '0;
            rdata_q <= '0;
`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.mem_valid) begin
                        word_q  <= offset[2 +: WORD_AW];
                        bank_q  <= bank_d;
                        wdata_q <= bus.mem_wdata;
                        wstrb_q <= bus.mem_wstrb;
`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
                        // Out-of-window requests never touch a macro.
                        if (oor) begin
                            state   <= ST_RESP;
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end else begin
                            state   <= ST_ACCESS;
                        end
`else
                        state   <= ST_ACCESS;
`endif
                    end
                end
                ST_ACCESS: begin
                    cnt   <= '0;
                    state <= (|wstrb_q) ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == 2'(LAT - 1)) begin
                        rdata_q <= dout[bank_q];
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_ready = (state == ST_RESP);
    assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_sram_bridge.sv
// Randomized bench for sram_bridge against a byte-array reference memory.
module tb_sram_bridge;

    localparam int          BANKS = 2;
    localparam int          LAT   = 3;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          CAP   = BANKS * 4096;
`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
    localparam bit          RC    = 1'b1;
`else
    localparam bit          RC    = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sram_bridge_if bus ();

    sram_bridge #(
        .BANKS     (BANKS),
        .LAT       (LAT),
        .BASE_ADDR (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ref_mem [CAP];
    logic [31:0] last_rd = '0;
    logic        exp_err = 1'b0;
    int          csb_lo [BANKS];

    initial begin
        for (int b = 0; b < BANKS; b++) csb_lo[b] = 0;
    end

    always @(posedge clk) begin
        for (int b = 0; b < BANKS; b++)
            if (!dut.csb[b]) csb_lo[b] = csb_lo[b] + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb);
        logic [31:0] off;
        logic [31:0] base;
        bit          oor;
        int          tbank;
        int          exp_lat;
        int          lat;
        bit          got;
        int          c0 [BANKS];

        off   = addr - BASE;
        oor   = RC && (off >= CAP);
        base  = (off % CAP) & ~32'd3;
        tbank = int'(base / 4096);
        if (oor)           exp_lat = 1;
        else if (wstrb != 0) exp_lat = 2;
        else               exp_lat = 2 + LAT;
        for (int b = 0; b < BANKS; b++) c0[b] = csb_lo[b];

        bus.mem_valid = 1'b1;
        bus.mem_instr = 1'($urandom);
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.mem_ready) got = 1'b1;
        end
        check("ready_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));

        if (oor) begin
            last_rd = '0;
            exp_err = 1'b1;
        end else if (wstrb != 0) begin
            for (int l = 0; l < 4; l++)
                if (wstrb[l]) ref_mem[base + l] = wdata[8*l +: 8];
        end else begin
            last_rd = {ref_mem[base+3], ref_mem[base+2],
                       ref_mem[base+1], ref_mem[base]};
        end
        check("rdata", bus.mem_rdata, last_rd);

        @(posedge clk);
        #1;
        check("ready_pulse", 32'(bus.mem_ready), 32'd0);
        bus.mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check("no_retrigger", 32'(bus.mem_ready), 32'd0);
        check("rdata_hold", bus.mem_rdata, last_rd);
        for (int b = 0; b < BANKS; b++)
            check($sformatf("csb_bank%0d", b), 32'(csb_lo[b] - c0[b]),
                  (b == tbank && !oor) ? 32'd1 : 32'd0);
`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
        check("mem_err", 32'(bus.mem_err), 32'(exp_err));
`endif
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;

        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'd0);
        check("rst_csb", 32'(dut.csb), 32'((1 << BANKS) - 1));
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_txn(32'h0, 32'h1234_5678, 4'hF);
        do_txn(32'h0, 32'h0, 4'h0);
        check("dir_rd0", bus.mem_rdata, 32'h1234_5678);

        do_txn(32'h4, 32'hAABB_CCDD, 4'hF);
        do_txn(32'h4, 32'h0000_EE00, 4'b0010);
        do_txn(32'h4, 32'h0, 4'h0);
        check("dir_partial", bus.mem_rdata, 32'hAABB_EEDD);

        do_txn(32'h0000, 32'h1111_1111, 4'hF);
        do_txn(32'h1000, 32'h2222_2222, 4'hF);
        do_txn(32'h0000, 32'h0, 4'h0);
        check("dir_bank0", bus.mem_rdata, 32'h1111_1111);
        do_txn(32'h1000, 32'h0, 4'h0);
        check("dir_bank1", bus.mem_rdata, 32'h2222_2222);

        for (int w = 0; w < CAP / 4; w++)
            do_txn(BASE + 32'(w * 4), $urandom, 4'hF);

        do_txn(BASE + 32'(CAP), 32'h0, 4'h0);

        for (int i = 0; i < 400; i++) begin
            a = BASE + 32'($urandom_range(0, 2 * CAP - 1));
            d = $urandom;
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            do_txn(a, d, s);
        end

        a = BASE + 32'h8;
        do_txn(a, 32'hCAFE_F00D, 4'hF);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = 32'h5555_AAAA;
        bus.mem_wstrb = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_mid_rdata", bus.mem_rdata, 32'd0);
        check("rst_mid_csb", 32'(dut.csb), 32'((1 << BANKS) - 1));
        bus.mem_valid = 1'b0;
        last_rd = '0;
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_txn(a, 32'h0, 4'h0);
        check("rst_no_commit", bus.mem_rdata, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
